// File: rtl/alu_operand_loader.sv
// Operand-capture front end: per-channel synchronise + debounce of active-low
// buttons, capture of the shared data bus on each clean press, valid tracking
// and a one-shot "all operands ready" pulse.
module alu_operand_loader #(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned NUM_OPS         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_OPS-1:0]        key_n_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      clear_i,
  output logic [NUM_OPS*DATA_W-1:0] operands_o,
  output logic [NUM_OPS-1:0]        load_pulse_o,
  output logic [NUM_OPS-1:0]        valid_o,
  output logic                      all_valid_o,
  output logic                      ready_pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_OPS-1:0] meta_q;            // first synchroniser stage
  logic [NUM_OPS-1:0] sync_q;            // synchronised key level
  logic [NUM_OPS-1:0] deb_q;             // debounced key level (1 = released)
  logic [CNT_W-1:0]   cnt_q [NUM_OPS];   // consecutive cycles sync_q != deb_q

  logic [NUM_OPS-1:0] press_c;
  logic [NUM_OPS-1:0] valid_nxt_c;
  logic               all_valid_nxt_c;

  // Press detection and next-state valid/all-valid
  always_comb begin
    press_c         = '0;
    valid_nxt_c     = '0;
    all_valid_nxt_c = 1'b0;
    for (int k = 0; k < int'(NUM_OPS); k++) begin
      press_c[k] = deb_q[k] & ~sync_q[k] & (cnt_q[k] == CNT_MAX);
    end
    valid_nxt_c     = (clear_i ? '0 : valid_o) | press_c;
    all_valid_nxt_c = &valid_nxt_c;
  end

  // Two-flop synchroniser and debounce counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
      deb_q  <= '1;
      for (int k = 0; k < int'(NUM_OPS); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      meta_q <= key_n_i;
      sync_q <= meta_q;
      for (int k = 0; k < int'(NUM_OPS); k++) begin
        if (sync_q[k] == deb_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CNT_MAX) begin
          deb_q[k] <= sync_q[k];
          cnt_q[k] <= '0;
        end else begin
          cnt_q[k] <= CNT_W'(cnt_q[k] + 1'b1);
        end
      end
    end
  end

  // Operand capture, pulses and valid tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      operands_o    <= '0;
      load_pulse_o  <= '0;
      valid_o       <= '0;
      all_valid_o   <= 1'b0;
      ready_pulse_o <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NUM_OPS); k++) begin
        if (press_c[k]) begin
          operands_o[k*DATA_W +: DATA_W] <= data_i;
        end
      end
      load_pulse_o  <= press_c;
      valid_o       <= valid_nxt_c;
      all_valid_o   <= all_valid_nxt_c;
      ready_pulse_o <= all_valid_nxt_c & ~all_valid_o;
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomised + directed bench for alu_operand_loader against a window-based
// behavioural model of the debounce and capture rules.
module tb_alu_operand_loader;

  localparam int unsigned DW = 16;
  localparam int unsigned NO = 3;
  localparam int unsigned DC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NO-1:0]     key_n;
  logic [DW-1:0]     data;
  logic              clear;
  logic [NO*DW-1:0]  operands;
  logic [NO-1:0]     load_pulse;
  logic [NO-1:0]     valid;
  logic              all_valid;
  logic              ready_pulse;

  alu_operand_loader #(
    .DATA_W          (DW),
    .NUM_OPS         (NO),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .key_n_i       (key_n),
    .data_i        (data),
    .clear_i       (clear),
    .operands_o    (operands),
    .load_pulse_o  (load_pulse),
    .valid_o       (valid),
    .all_valid_o   (all_valid),
    .ready_pulse_o (ready_pulse)
  );

  always #5 clk = ~clk;

  // Model: hist[0] is the key level sampled at the latest edge; the level the
  // debouncer sees at an edge is the key two edges earlier (hist[2]).
  logic [NO-1:0]    hist [DC+2];
  logic [NO-1:0]    m_deb;
  logic [NO-1:0]    m_valid;
  logic [NO-1:0]    m_load;
  logic             m_all;
  logic             m_ready;
  logic [NO*DW-1:0] m_ops;

  int n_cmp = 0;
  int n_bad = 0;
  int load_cnt [NO];
  int ready_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DC) + 2; i++) hist[i] = '1;
    m_deb   = '1;
    m_valid = '0;
    m_load  = '0;
    m_all   = 1'b0;
    m_ready = 1'b0;
    m_ops   = '0;
  endtask

  // A debounced level flips once the seen level has disagreed with it for the
  // last DC edges in a row; a 1->0 flip is a press.
  task automatic model_step();
    logic [NO-1:0] press;
    logic [NO-1:0] nv;
    logic          stable;
    press = '0;
    for (int i = int'(DC) + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = key_n;
    for (int k = 0; k < int'(NO); k++) begin
      stable = 1'b1;
      for (int i = 2; i < int'(DC) + 2; i++)
        if (hist[i][k] == m_deb[k]) stable = 1'b0;
      if (stable) begin
        if (m_deb[k]) press[k] = 1'b1;
        m_deb[k] = ~m_deb[k];
      end
    end
    for (int k = 0; k < int'(NO); k++)
      if (press[k]) m_ops[k*DW +: DW] = data;
    m_load  = press;
    nv      = (clear ? '0 : m_valid) | press;
    m_ready = (&nv) & ~m_all;
    m_all   = &nv;
    m_valid = nv;
  endtask

  task automatic check_all();
    chk("operands", 64'(operands), 64'(m_ops));
    chk("load_pulse", 64'(load_pulse), 64'(m_load));
    chk("valid", 64'(valid), 64'(m_valid));
    chk("all_valid", 64'(all_valid), 64'(m_all));
    chk("ready_pulse", 64'(ready_pulse), 64'(m_ready));
  endtask

  // One clock: advance model, let the edge happen, compare just after it.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    for (int k = 0; k < int'(NO); k++) if (load_pulse[k]) load_cnt[k]++;
    if (ready_pulse) ready_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press_key(input int k, input logic [DW-1:0] d);
    data     = d;
    key_n[k] = 1'b0;
    run(8);
    key_n[k] = 1'b1;
    run(8);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < int'(NO); k++) load_cnt[k] = 0;
    ready_cnt = 0;
  endtask

  initial begin
    int lat;
    int r;
    logic [DW-1:0] op;
    rst   = 1'b1;
    key_n = '1;
    data  = 16'h1234;
    clear = 1'b0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst = 1'b0;

    // First press: latency and capture
    run(9);
    key_n[0] = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      lat++;
      if (load_pulse[0]) break;
    end
    chk("press_latency", 64'(lat), 64'd6);
    op = operands[0 +: DW];
    chk("operand0_first", 64'(op), 64'h1234);
    chk("valid_first", 64'(valid), 64'b001);
    key_n[0] = 1'b1;
    run(8);

    // Bounce then real press on channel 1
    clear_counts();
    data = 16'h00FF;
    key_n[1] = 1'b0; run(3);
    key_n[1] = 1'b1; run(3);
    key_n[1] = 1'b0; run(10);
    key_n[1] = 1'b1; run(8);
    chk("bounce_captures", 64'(load_cnt[1]), 64'd1);
    op = operands[DW +: DW];
    chk("operand1_bounce", 64'(op), 64'h00FF);

    // Sequential loads of all three channels
    clear = 1'b1; cycle(); clear = 1'b0;
    clear_counts();
    press_key(0, 16'hA);
    press_key(1, 16'hB);
    press_key(2, 16'hC);
    chk("ops_abc", 64'(operands), 64'({16'hC, 16'hB, 16'hA}));
    chk("all_valid_abc", 64'(all_valid), 64'd1);
    chk("ready_count_abc", 64'(ready_cnt), 64'd1);

    // Re-press of an already valid channel
    clear_counts();
    press_key(2, 16'hD);
    op = operands[2*DW +: DW];
    chk("operand2_repress", 64'(op), 64'hD);
    chk("ready_count_repress", 64'(ready_cnt), 64'd0);
    chk("load_count_repress", 64'(load_cnt[2]), 64'd1);

    // Clear coinciding with channel 0 capture
    data = 16'h5555;
    key_n[0] = 1'b0;
    run(5);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clear_capture_valid", 64'(valid), 64'b001);
    chk("clear_capture_load", 64'(load_pulse), 64'b001);
    chk("clear_capture_ops", 64'(operands), 64'({16'hD, 16'hB, 16'h5555}));
    key_n[0] = 1'b1;
    run(8);

    // Reset mid-debounce with key held through release
    key_n[1] = 1'b0;
    run(4);
    do_reset();
    clear_counts();
    run(20);
    chk("held_through_reset_captures", 64'(load_cnt[1]), 64'd1);
    key_n[1] = 1'b1;
    run(8);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < int'(NO); k++)
        if ($urandom_range(5) == 0) key_n[k] = ~key_n[k];
      data  = DW'($urandom);
      clear = ($urandom_range(39) == 0);
      r = int'($urandom_range(599));
      if (r == 0) do_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
